serial_full_subtractor: RTL

// Bit-serial subtractor, the inverse of the ripple full-adder datapath. Computes

---
 rtl/serial_full_subtractor.sv | 96 +++++++++
 1 files changed

// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first,
// through a single full-subtractor cell and a registered borrow.
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic             borrow;
    logic [CW-1:0]    count;
    logic             d_bit;
    logic             c_next;

    function automatic logic sub_diff(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic sub_borrow(input logic x, input logic y, input logic c);
        return (~x & y) | (~(x ^ y) & c);
    endfunction

    always_comb begin
        d_bit  = sub_diff(a_sr[0], b_sr[0], borrow);
        c_next = sub_borrow(a_sr[0], b_sr[0], borrow);
    end

    // rst_n gates in_ready so no operand is taken while reset is asserted.
    assign in_ready = (state == IDLE) & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            borrow    <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        count  <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
                    borrow  <= c_next;
                    if (count == LAST) begin
                        diff      <= {d_bit, diff_sr[WIDTH-1:1]};
                        bout      <= c_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
